vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Owns the single-port frame memory (VRAM) and shares it between two requesters: the scan-out reader driven by the VGA timing enables, and a pixel writer (drawing engine / host) using a valid/ready handshake.
- Scan-out has absolute priority: every visible pixel slot gets a read, and the writer fills the remaining cycles.
- Sits between the hsync/vsync timing blocks and the VRAM macro, and feeds the RGB output stage.

Parameters:
- ADDR_BIT, 19, VRAM address width; 640*480 fits in 19 bits.
- DATA_BIT, 8, pixel width (RGB332).
- FRAME_PX, 307200, visible pixels per frame; the read address wraps at this value.

Ports:
- clk  in  1  system clock
- i_arst_n  in  1  asynchronous active-low reset
- i_px_clk  in  1  one-cycle pixel enable pulse
- i_hvis  in  1  horizontal visible window (from hsync)
- i_vvis  in  1  vertical visible window (vsync o_addr_en)
- i_frame_start  in  1  one-cycle pulse at the start of the vsync pulse
- i_wr_valid  in  1  writer request
- o_wr_ready  out  1  writer accept
- i_wr_addr  in  ADDR_BIT  writer address
- i_wr_data  in  DATA_BIT  writer data
- o_mem_en  out  1  VRAM access enable (registered)
- o_mem_we  out  1  VRAM write enable (registered)
- o_mem_addr  out  ADDR_BIT  VRAM address (registered)
- o_mem_wdata  out  DATA_BIT  VRAM write data (registered)
- i_mem_rdata  in  DATA_BIT  VRAM read data, 1-cycle registered-read latency
- o_pix_valid  out  1  pixel data valid strobe
- o_pix_data  out  DATA_BIT  scan-out pixel

Behaviour:
- Reset (async, i_arst_n=0):
  - State is S_IDLE, the read address counter is 0.
  - All of o_mem_*, o_pix_valid and o_pix_data are 0; o_wr_ready is 0.
- Read slot: s_rd_slot = i_px_clk & i_hvis & i_vvis, decided combinationally in cycle N.
- FSM state names the command registered onto the memory port: S_IDLE, S_RD, S_WR. The next state is evaluated every cycle:
  - s_rd_slot -> S_RD: o_mem_en=1, o_mem_we=0, o_mem_addr = read counter.
  - else i_wr_valid & o_wr_ready -> S_WR: o_mem_en=1, o_mem_we=1, addr and data taken from i_wr_addr/i_wr_data.
  - else -> S_IDLE: o_mem_en=0, o_mem_we=0; addr and wdata hold their last value.
- o_wr_ready = i_arst_n & ~s_rd_slot, combinational. A write transfers only when valid & ready in the same cycle. The writer must hold its addr and data stable while valid & ~ready.
- Read latency:
  - Slot in cycle N -> command on the port in N+1 -> i_mem_rdata valid in N+2.
  - o_pix_data is latched at the end of N+2; o_pix_valid is high for exactly cycle N+3.
  - o_pix_data holds its value between strobes.
- Read counter:
  - Increments after each slot; FRAME_PX-1 wraps to 0.
  - i_frame_start clears it to 0 at the same edge. A clear coinciding with a slot lets that slot use the old value; the clear wins the counter update.
- Back-to-back slots, which occur when i_px_clk is tied high, are legal. The writer then starves indefinitely while visible; this is permitted.
- Writes arriving in blanking (i_hvis=0 or i_vvis=0) are accepted every cycle, giving one write per clk.
- Address range on writes is not checked; any value ≥ FRAME_PX is passed through unchanged.
- Reset mid-frame: the counter returns to 0, and scan-out realigns at the next i_frame_start.

Optional Feature:
- VRAM_WR_FIFO_EN defined:
  - A 4-entry write FIFO (addr+data) sits between the writer port and the arbiter.
  - o_wr_ready = FIFO not full, so it is independent of s_rd_slot. The FIFO head is issued on any non-slot cycle.
  - A push to a full FIFO is impossible because ready is low; simultaneous push and pop when full is not allowed.
  - Reset empties the FIFO.
  - Memory write ordering equals acceptance order.
- VRAM_WR_FIFO_EN not defined:
  - Direct handshake as specified above.

Decomposition:
- Shared package / include: state encodings S_IDLE=2'd0, S_RD=2'd1, S_WR=2'd2, plus 640x480 geometry constants (FRAME_PX, ADDR_BIT).
- The read address counter reuses the existing counterN_en (N=FRAME_PX, width ADDR_BIT, i_en=s_rd_slot, i_sclr=i_frame_start). The async reset is added as an outer condition.
- One sub-module, vram_wr_fifo, exists only under VRAM_WR_FIFO_EN.

Test Plan:
- Reset asserted mid-operation -> all outputs 0 asynchronously; after release, the first slot reads address 0.
- Visible window, i_px_clk every 4th cycle, writer idle -> o_mem_addr sequence 0,1,2,3 one cycle after each slot; o_pix_valid 3 cycles after each slot with data from a memory model.
- Blanking, i_wr_valid held for 5 cycles with addr 0x100..0x104 -> 5 consecutive S_WR commands with matching addr/data, then o_mem_en=0.
- Writer valid on the same cycle as a slot -> o_wr_ready=0 in that cycle; the read wins, and the write is accepted in the next non-slot cycle with unchanged addr/data.
- Drive 307200 slots -> counter wraps to 0 on slot 307201. An i_frame_start pulse at count 1234 -> the next slot reads 0.
- VRAM_WR_FIFO_EN: 6 writes pushed during continuous slots -> ready drops after 4 accepted; all 4 are issued in order at the first blanking cycles, then the remaining 2.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// rtl/vram_arbiter_pkg.sv - memory-port command encodings and 640x480 geometry for the VRAM arbiter
package vram_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2
   } state_t;

   localparam int GEOM_H_PX     = 640;
   localparam int GEOM_V_PX     = 480;
   localparam int GEOM_FRAME_PX = GEOM_H_PX * GEOM_V_PX;
   localparam int GEOM_ADDR_BIT = 19;
   localparam int GEOM_DATA_BIT = 8;
   localparam int WR_FIFO_DEPTH = 4;

endpackage

// File: rtl/counterN_en.sv
// rtl/counterN_en.sv - modulo-N enabled counter with synchronous clear and async active-low reset
module counterN_en #(
   parameter int N = 307200,
   parameter int W = 19
) (
   input  logic         clk,
   input  logic         i_arst_n,
   input  logic         i_en,
   input  logic         i_sclr,
   output logic [W-1:0] o_cnt
);

   always_ff @(posedge clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         o_cnt <= '0;
      end else if (i_sclr) begin
         o_cnt <= '0;
      end else if (i_en) begin
         o_cnt <= (o_cnt == W'(N - 1)) ? '0 : o_cnt + W'(1);
      end
   end

endmodule

// File: rtl/vram_wr_fifo.sv
// rtl/vram_wr_fifo.sv - 4-entry address+data write FIFO, used only when VRAM_WR_FIFO_EN is defined
module vram_wr_fifo
   import vram_arbiter_pkg::*;
#(
   parameter int ADDR_BIT = GEOM_ADDR_BIT,
   parameter int DATA_BIT = GEOM_DATA_BIT
) (
   input  logic                clk,
   input  logic                i_arst_n,
   input  logic                i_push,
   input  logic [ADDR_BIT-1:0] i_addr,
   input  logic [DATA_BIT-1:0] i_data,
   input  logic                i_pop,
   output logic [ADDR_BIT-1:0] o_addr,
   output logic [DATA_BIT-1:0] o_data,
   output logic                o_full,
   output logic                o_empty
);

   logic [ADDR_BIT-1:0] addr_q [WR_FIFO_DEPTH];
   logic [DATA_BIT-1:0] data_q [WR_FIFO_DEPTH];
   logic [1:0]          wr_ptr;
   logic [1:0]          rd_ptr;
   logic [2:0]          count;

   assign o_full  = (count == 3'(WR_FIFO_DEPTH));
   assign o_empty = (count == 3'd0);
   assign o_addr  = addr_q[rd_ptr];
   assign o_data  = data_q[rd_ptr];

   // Storage is not reset; only the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (i_push) begin
         addr_q[wr_ptr] <= i_addr;
         data_q[wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (i_push) wr_ptr <= wr_ptr + 2'd1;
         if (i_pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({i_push, i_pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - VRAM port arbiter: scan-out reads take priority, writer fills idle cycles (VRAM_WR_FIFO_EN adds a write FIFO)
module vram_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int ADDR_BIT = GEOM_ADDR_BIT,
   parameter int DATA_BIT = GEOM_DATA_BIT,
   parameter int FRAME_PX = GEOM_FRAME_PX
) (
   input  logic                clk,
   input  logic                i_arst_n,
   input  logic                i_px_clk,
   input  logic                i_hvis,
   input  logic                i_vvis,
   input  logic                i_frame_start,
   input  logic                i_wr_valid,
   output logic                o_wr_ready,
   input  logic [ADDR_BIT-1:0] i_wr_addr,
   input  logic [DATA_BIT-1:0] i_wr_data,
   output logic                o_mem_en,
   output logic                o_mem_we,
   output logic [ADDR_BIT-1:0] o_mem_addr,
   output logic [DATA_BIT-1:0] o_mem_wdata,
   input  logic [DATA_BIT-1:0] i_mem_rdata,
   output logic                o_pix_valid,
   output logic [DATA_BIT-1:0] o_pix_data
);

   logic                s_rd_slot;
   logic [ADDR_BIT-1:0] rd_cnt;
   logic                wr_go;
   logic [ADDR_BIT-1:0] wr_addr;
   logic [DATA_BIT-1:0] wr_data;
   state_t              state;
   logic                rd_d1;

   assign s_rd_slot = i_px_clk & i_hvis & i_vvis;

   counterN_en #(
      .N (FRAME_PX),
      .W (ADDR_BIT)
   ) u_rd_cnt (
      .clk      (clk),
      .i_arst_n (i_arst_n),
      .i_en     (s_rd_slot),
      .i_sclr   (i_frame_start),
      .o_cnt    (rd_cnt)
   );

`ifdef VRAM_WR_FIFO_EN
   logic fifo_full;
   logic fifo_empty;

   assign o_wr_ready = i_arst_n & ~fifo_full;
   assign wr_go      = ~s_rd_slot & ~fifo_empty;

   vram_wr_fifo #(
      .ADDR_BIT (ADDR_BIT),
      .DATA_BIT (DATA_BIT)
   ) u_wr_fifo (
      .clk      (clk),
      .i_arst_n (i_arst_n),
      .i_push   (i_wr_valid & o_wr_ready),
      .i_addr   (i_wr_addr),
      .i_data   (i_wr_data),
      .i_pop    (wr_go),
      .o_addr   (wr_addr),
      .o_data   (wr_data),
      .o_full   (fifo_full),
      .o_empty  (fifo_empty)
   );
`else
   assign o_wr_ready = i_arst_n & ~s_rd_slot;
   assign wr_go      = i_wr_valid & o_wr_ready;
   assign wr_addr    = i_wr_addr;
   assign wr_data    = i_wr_data;
`endif

   // rd_d1 marks the cycle in which the VRAM returns data for a read issued one cycle earlier.
   always_ff @(posedge clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state       <= S_IDLE;
         o_mem_en    <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         rd_d1       <= 1'b0;
         o_pix_valid <= 1'b0;
         o_pix_data  <= '0;
      end else begin
         rd_d1       <= (state == S_RD);
         o_pix_valid <= rd_d1;
         if (rd_d1) o_pix_data <= i_mem_rdata;

         if (s_rd_slot) begin
            state      <= S_RD;
            o_mem_en   <= 1'b1;
            o_mem_we   <= 1'b0;
            o_mem_addr <= rd_cnt;
         end else if (wr_go) begin
            state       <= S_WR;
            o_mem_en    <= 1'b1;
            o_mem_we    <= 1'b1;
            o_mem_addr  <= wr_addr;
            o_mem_wdata <= wr_data;
         end else begin
            state    <= S_IDLE;
            o_mem_en <= 1'b0;
            o_mem_we <= 1'b0;
         end
      end
   end

endmodule
